// File: rtl/lane_rot_shift_pkg.sv
// lane_rot_shift_pkg
//   Shared definitions for the lane rotator/shifter pipeline:
//     - mode encodings OP_ROL .. OP_SRA (101-111 are reserved)
//     - clog2(): ceiling log2 usable in parameter expressions
//     - is_reserved(): true for the reserved mode encodings
//     - LRS_PARAM_CHECK: elaboration-time parameter guard
//       LRS_PARAM_CHECK(label, condition, message)
`ifndef LANE_ROT_SHIFT_PKG_SV
`define LANE_ROT_SHIFT_PKG_SV

`define LRS_PARAM_CHECK(label, cond, msg) \
   if (!(cond)) begin : label \
      $error(msg); \
   end

package lane_rot_shift_pkg;

   localparam logic [2:0] OP_ROL = 3'b000;
   localparam logic [2:0] OP_ROR = 3'b001;
   localparam logic [2:0] OP_SLL = 3'b010;
   localparam logic [2:0] OP_SRL = 3'b011;
   localparam logic [2:0] OP_SRA = 3'b100;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   function automatic logic is_reserved(input logic [2:0] op);
      return op > OP_SRA;
   endfunction

endpackage

`endif

// File: rtl/lane_rot_shift_level.sv
// lane_rot_shift_level
//   One combinational level of the lane network. When en is set the word is
//   moved by DIST lanes in the direction and with the fill that op selects;
//   otherwise, or for a reserved op, data passes through unchanged.
//   Parameters: DATA_W (word width), LANE_W (lane width), DIST (lanes moved)
//   Ports:
//     data_i  in   DATA_W  word entering this level
//     en      in   1       amount bit belonging to this level
//     op      in   3       mode encoding
//     data_o  out  DATA_W  word leaving this level
module lane_rot_shift_level
   import lane_rot_shift_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LANE_W = 8,
   parameter int DIST   = 1
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic              en,
   input  logic [2:0]        op,
   output logic [DATA_W-1:0] data_o
);

   localparam int SH = DIST * LANE_W;

   // Arithmetic right shift keeps the MSB intact, so chaining SRA levels
   // still fills with the sign of the original operand.
   always_comb begin
      // NOTE: data_o is assigned before any branch so every path drives it
      // and no latch is inferred.
      data_o = data_i;
      if (en) begin
         case (op)
            OP_ROL:  data_o = {data_i[DATA_W-SH-1:0], data_i[DATA_W-1:DATA_W-SH]};
            OP_ROR:  data_o = {data_i[SH-1:0], data_i[DATA_W-1:SH]};
            OP_SLL:  data_o = {data_i[DATA_W-SH-1:0], {SH{1'b0}}};
            OP_SRL:  data_o = {{SH{1'b0}}, data_i[DATA_W-1:SH]};
            OP_SRA:  data_o = {{SH{data_i[DATA_W-1]}}, data_i[DATA_W-1:SH]};
            default: data_o = data_i;
         endcase
      end
   end

endmodule

// File: rtl/lane_rot_shift_pipe.sv
// lane_rot_shift_pipe
//   Pipelined lane rotator/shifter (ROL, ROR, SLL, SRL, SRA) with valid/ready
//   on both sides. The amount counts LANE_W-bit lanes. Latency is PIPE_STAGES
//   cycles; full throughput, with no bubbles on simultaneous fill and drain.
//   Ports:
//     clk_i        in   1       clock, rising edge
//     rst_i        in   1       synchronous active-high reset
//     in_valid_i   in   1       input transfer request
//     in_ready_o   out  1       input can be accepted this cycle
//     operand_i    in   DATA_W  word to rotate or shift
//     amount_i     in   AMT_W   distance in lanes
//     op_i         in   3       mode
//     tag_i        in   TAG_W   sideband tag, carried unmodified
//     out_valid_o  out  1       result available
//     out_ready_i  in   1       downstream accepts the result
//     result_o     out  DATA_W  rotated or shifted word
//     tag_o        out  TAG_W   tag of result_o
//     illegal_o    out  1       op was a reserved encoding
//     zero_o       out  1       result_o == 0
module lane_rot_shift_pipe
   import lane_rot_shift_pkg::*;
#(
   parameter int  DATA_W      = 32,
   parameter int  LANE_W      = 8,
   parameter int  PIPE_STAGES = 2,
   parameter int  TAG_W       = 4,
   localparam int NLANE       = DATA_W / LANE_W,
   localparam int AMT_W       = clog2(NLANE)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] operand_i,
   input  logic [AMT_W-1:0]  amount_i,
   input  logic [2:0]        op_i,
   input  logic [TAG_W-1:0]  tag_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] result_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic              illegal_o,
   output logic              zero_o
);

   `LRS_PARAM_CHECK(g_chk_stages, (PIPE_STAGES == 1) || (PIPE_STAGES == 2),
                    "lane_rot_shift_pipe: PIPE_STAGES must be 1 or 2")
   `LRS_PARAM_CHECK(g_chk_lane_div, (LANE_W > 0) && (DATA_W % LANE_W == 0),
                    "lane_rot_shift_pipe: DATA_W must be a multiple of LANE_W")
   `LRS_PARAM_CHECK(g_chk_nlane, (NLANE >= 2) && ((1 << AMT_W) == NLANE),
                    "lane_rot_shift_pipe: DATA_W/LANE_W must be a power of 2, >= 2")

   // Item presented to the output register by the last network level.
   logic              fin_valid;
   logic [DATA_W-1:0] fin_data;
   logic [2:0]        fin_op;
   logic [TAG_W-1:0]  fin_tag;

   // Output register loads when empty or its item leaves this cycle.
   logic load_out;
   assign load_out = !out_valid_o || out_ready_i;

   if (PIPE_STAGES == 1) begin : g_one
      logic [AMT_W:0][DATA_W-1:0] chain;
      assign chain[0] = operand_i;

      for (genvar j = 0; j < AMT_W; j++) begin : g_lvl
         lane_rot_shift_level #(
            .DATA_W (DATA_W),
            .LANE_W (LANE_W),
            .DIST   (1 << j)
         ) u_level (
            .data_i (chain[j]),
            .en     (amount_i[j]),
            .op     (op_i),
            .data_o (chain[j+1])
         );
      end

      assign fin_valid  = in_valid_i;
      assign fin_data   = chain[AMT_W];
      assign fin_op     = op_i;
      assign fin_tag    = tag_i;
      assign in_ready_o = load_out;
   end else begin : g_two
      // Low levels run before the mid register, high levels after it.
      localparam int SPLIT = AMT_W / 2;

      logic [SPLIT:0][DATA_W-1:0]       front;
      logic [AMT_W-SPLIT:0][DATA_W-1:0] back;
      logic                             mid_valid;
      logic [DATA_W-1:0]                mid_data;
      logic [AMT_W-1:SPLIT]             mid_amt;
      logic [2:0]                       mid_op;
      logic [TAG_W-1:0]                 mid_tag;
      logic                             load_mid;

      // Mid stage frees up whenever the output register takes its item.
      assign load_mid = !mid_valid || load_out;

      assign front[0] = operand_i;
      for (genvar j = 0; j < SPLIT; j++) begin : g_front
         lane_rot_shift_level #(
            .DATA_W (DATA_W),
            .LANE_W (LANE_W),
            .DIST   (1 << j)
         ) u_level (
            .data_i (front[j]),
            .en     (amount_i[j]),
            .op     (op_i),
            .data_o (front[j+1])
         );
      end

      always_ff @(posedge clk_i) begin
         // NOTE: only the valid bit is reset here. The payload is written
         // only together with a set valid and never observed otherwise, so
         // clearing it would add reset fan-out for no behavioural change.
         if (rst_i) begin
            mid_valid <= 1'b0;
         end else if (load_mid) begin
            mid_valid <= in_valid_i;
            if (in_valid_i) begin
               mid_data <= front[SPLIT];
               mid_amt  <= amount_i[AMT_W-1:SPLIT];
               mid_op   <= op_i;
               mid_tag  <= tag_i;
            end
         end
      end

      assign back[0] = mid_data;
      for (genvar j = SPLIT; j < AMT_W; j++) begin : g_back
         lane_rot_shift_level #(
            .DATA_W (DATA_W),
            .LANE_W (LANE_W),
            .DIST   (1 << j)
         ) u_level (
            .data_i (back[j-SPLIT]),
            .en     (mid_amt[j]),
            .op     (mid_op),
            .data_o (back[j-SPLIT+1])
         );
      end

      assign fin_valid  = mid_valid;
      assign fin_data   = back[AMT_W-SPLIT];
      assign fin_op     = mid_op;
      assign fin_tag    = mid_tag;
      assign in_ready_o = load_mid;
   end

   // Output register. Payload is cleared on reset because it is visible on
   // the ports, and it only changes when a new item is taken.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      if (rst_i) begin
         out_valid_o <= 1'b0;
         result_o    <= '0;
         tag_o       <= '0;
         illegal_o   <= 1'b0;
      end else if (load_out) begin
         out_valid_o <= fin_valid;
         if (fin_valid) begin
            result_o  <= fin_data;
            tag_o     <= fin_tag;
            illegal_o <= is_reserved(fin_op);
         end
      end
   end

   assign zero_o = (result_o == '0);

endmodule

// File: tb/tb_lane_rot_shift_pipe.sv
// tb_lane_rot_shift_pipe
//   Drives two instances: the default configuration (A: 8-bit lanes, two
//   stages) and a bit-level single-stage one (B: LANE_W=1, PIPE_STAGES=1).
//   Accepted inputs are pushed into per-instance scoreboards with results
//   from a lane-array reference model; outputs are checked in order.
module tb_lane_rot_shift_pipe;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst_i;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- DUT A: defaults ----------------
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_illegal, a_zero;
   logic [31:0] a_operand, a_result;
   logic [1:0]  a_amount;
   logic [2:0]  a_op;
   logic [3:0]  a_tag_in, a_tag_out;

   lane_rot_shift_pipe u_dut_a (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .in_valid_i  (a_in_valid),
      .in_ready_o  (a_in_ready),
      .operand_i   (a_operand),
      .amount_i    (a_amount),
      .op_i        (a_op),
      .tag_i       (a_tag_in),
      .out_valid_o (a_out_valid),
      .out_ready_i (a_out_ready),
      .result_o    (a_result),
      .tag_o       (a_tag_out),
      .illegal_o   (a_illegal),
      .zero_o      (a_zero)
   );

   // ---------------- DUT B: bit-level, one stage ----------------
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_illegal, b_zero;
   logic [31:0] b_operand, b_result;
   logic [4:0]  b_amount;
   logic [2:0]  b_op;
   logic [3:0]  b_tag_in, b_tag_out;

   lane_rot_shift_pipe #(
      .DATA_W      (32),
      .LANE_W      (1),
      .PIPE_STAGES (1),
      .TAG_W       (4)
   ) u_dut_b (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .in_valid_i  (b_in_valid),
      .in_ready_o  (b_in_ready),
      .operand_i   (b_operand),
      .amount_i    (b_amount),
      .op_i        (b_op),
      .tag_i       (b_tag_in),
      .out_valid_o (b_out_valid),
      .out_ready_i (b_out_ready),
      .result_o    (b_result),
      .tag_o       (b_tag_out),
      .illegal_o   (b_illegal),
      .zero_o      (b_zero)
   );

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", name, obs, exp, $time);
      end
   endtask

   // Reference model: the word is viewed as an array of lanes, lane 0 least
   // significant; each result lane is picked from a source lane or filled.
   function automatic logic [31:0] lane_of(input logic [31:0] x, input int k, input int lw);
      logic [31:0] mask;
      mask = (32'd1 << lw) - 32'd1;
      return (x >> (k * lw)) & mask;
   endfunction

   function automatic logic [31:0] model(input logic [31:0] x, input int a,
                                         input logic [2:0] op, input int lw);
      int          nl;
      logic [31:0] fill;
      logic [31:0] r;
      logic [31:0] v;
      nl   = 32 / lw;
      fill = x[31] ? ((32'd1 << lw) - 32'd1) : 32'd0;
      r    = 32'd0;
      if (op > 3'd4) return x;
      for (int i = 0; i < nl; i++) begin
         case (op)
            3'd0:    v = lane_of(x, (i - a + nl) % nl, lw);
            3'd1:    v = lane_of(x, (i + a) % nl, lw);
            3'd2:    v = (i >= a) ? lane_of(x, i - a, lw) : 32'd0;
            3'd3:    v = (i + a < nl) ? lane_of(x, i + a, lw) : 32'd0;
            default: v = (i + a < nl) ? lane_of(x, i + a, lw) : fill;
         endcase
         r = r | (v << (i * lw));
      end
      return r;
   endfunction

   // ---------------- scoreboards / monitors ----------------
   exp_t        a_q[$];
   exp_t        b_q[$];
   int          a_outs = 0, b_outs = 0;
   int          a_last_cyc = -10, a_streak = 0;
   logic [31:0] a_last_res, b_last_res;
   logic        a_last_ill, a_last_zero;

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (!rst_i) begin
         if (a_in_valid && a_in_ready) begin
            e.res = model(a_operand, int'(a_amount), a_op, 8);
            e.tag = a_tag_in;
            e.ill = (a_op > 3'd4);
            a_q.push_back(e);
         end
         if (a_out_valid && a_out_ready) begin
            check("a_out_expected", 64'(a_q.size() != 0), 64'(1));
            if (a_q.size() != 0) begin
               e = a_q.pop_front();
               check("a_result", 64'(a_result), 64'(e.res));
               check("a_tag", 64'(a_tag_out), 64'(e.tag));
               check("a_illegal", 64'(a_illegal), 64'(e.ill));
               check("a_zero", 64'(a_zero), 64'(e.res == 32'd0));
            end
            a_outs++;
            a_last_res  = a_result;
            a_last_ill  = a_illegal;
            a_last_zero = a_zero;
            a_streak    = (a_last_cyc == cyc - 1) ? a_streak + 1 : 1;
            a_last_cyc  = cyc;
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (!rst_i) begin
         if (b_in_valid && b_in_ready) begin
            e.res = model(b_operand, int'(b_amount), b_op, 1);
            e.tag = b_tag_in;
            e.ill = (b_op > 3'd4);
            b_q.push_back(e);
         end
         if (b_out_valid && b_out_ready) begin
            check("b_out_expected", 64'(b_q.size() != 0), 64'(1));
            if (b_q.size() != 0) begin
               e = b_q.pop_front();
               check("b_result", 64'(b_result), 64'(e.res));
               check("b_tag", 64'(b_tag_out), 64'(e.tag));
               check("b_illegal", 64'(b_illegal), 64'(e.ill));
               check("b_zero", 64'(b_zero), 64'(e.res == 32'd0));
            end
            b_outs++;
            b_last_res = b_result;
         end
      end
   end

   // ---------------- drivers (called at posedge + 1) ----------------
   task automatic a_send(input logic [31:0] x, input logic [1:0] amt,
                         input logic [2:0] op, input logic [3:0] tag);
      bit done = 1'b0;
      a_in_valid = 1'b1; a_operand = x; a_amount = amt; a_op = op; a_tag_in = tag;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         done = a_in_ready;
         @(posedge clk); #1;
      end
      check("a_input_accepted", 64'(done), 64'(1));
   endtask

   task automatic b_send(input logic [31:0] x, input logic [4:0] amt,
                         input logic [2:0] op, input logic [3:0] tag);
      bit done = 1'b0;
      b_in_valid = 1'b1; b_operand = x; b_amount = amt; b_op = op; b_tag_in = tag;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         done = b_in_ready;
         @(posedge clk); #1;
      end
      check("b_input_accepted", 64'(done), 64'(1));
   endtask

   // One item into an empty pipe: measures latency and checks the result.
   task automatic a_single(input string name, input logic [31:0] x, input logic [1:0] amt,
                           input logic [2:0] op, input logic [31:0] exp_res);
      int lat  = 0;
      bit seen = 1'b0;
      a_out_ready = 1'b1;
      a_in_valid = 1'b1; a_operand = x; a_amount = amt; a_op = op; a_tag_in = 4'hA;
      while (!seen && lat < 20) begin
         @(posedge clk); lat++; #1;
         a_in_valid = 1'b0;
         @(negedge clk);
         seen = a_out_valid;
      end
      @(posedge clk); #1;
      check({name, "_latency"}, 64'(lat), 64'(2));
      check({name, "_result"}, 64'(a_last_res), 64'(exp_res));
   endtask

   task automatic b_single(input string name, input logic [31:0] x, input logic [4:0] amt,
                           input logic [2:0] op, input logic [31:0] exp_res);
      int lat  = 0;
      bit seen = 1'b0;
      b_out_ready = 1'b1;
      b_in_valid = 1'b1; b_operand = x; b_amount = amt; b_op = op; b_tag_in = 4'h5;
      while (!seen && lat < 20) begin
         @(posedge clk); lat++; #1;
         b_in_valid = 1'b0;
         @(negedge clk);
         seen = b_out_valid;
      end
      @(posedge clk); #1;
      check({name, "_latency"}, 64'(lat), 64'(1));
      check({name, "_result"}, 64'(b_last_res), 64'(exp_res));
   endtask

   task automatic drain_all();
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      for (int c = 0; c < 300 && (a_q.size() != 0 || b_q.size() != 0); c++) begin
         @(posedge clk); #1;
      end
      check("a_drained", 64'(a_q.size()), 64'(0));
      check("b_drained", 64'(b_q.size()), 64'(0));
   endtask

   task automatic a_rand(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            a_in_valid = 1'b0;
            @(posedge clk); #1;
         end
         a_send($urandom, 2'($urandom), 3'($urandom), 4'($urandom));
      end
      a_in_valid = 1'b0;
   endtask

   task automatic b_rand(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            b_in_valid = 1'b0;
            @(posedge clk); #1;
         end
         b_send($urandom, 5'($urandom), 3'($urandom), 4'($urandom));
      end
      b_in_valid = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   logic [31:0] st_x[6];
   logic [1:0]  st_a[6];
   logic [2:0]  st_op[6];
   bit          rand_busy;

   initial begin : main
      int          c0, o0, k;
      bit          fired, held_set;
      logic [31:0] held;

      rst_i = 1'b1;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_operand = '0; a_amount = '0; a_op = '0; a_tag_in = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_operand = '0; b_amount = '0; b_op = '0; b_tag_in = '0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_a_out_valid", 64'(a_out_valid), 64'(0));
      check("rst_a_result", 64'(a_result), 64'(0));
      check("rst_a_tag", 64'(a_tag_out), 64'(0));
      check("rst_a_illegal", 64'(a_illegal), 64'(0));
      check("rst_a_zero", 64'(a_zero), 64'(1));
      check("rst_a_in_ready", 64'(a_in_ready), 64'(1));
      check("rst_b_out_valid", 64'(b_out_valid), 64'(0));
      check("rst_b_in_ready", 64'(b_in_ready), 64'(1));
      @(posedge clk); #1;

      // Directed mode cases
      a_single("rol_a1", 32'h44332211, 2'd1, 3'b000, 32'h33221144);
      a_single("rol_a3", 32'h44332211, 2'd3, 3'b000, 32'h11443322);
      a_single("sra_a2", 32'h80FF0011, 2'd2, 3'b100, 32'hFFFF80FF);
      a_single("srl_a2", 32'h80FF0011, 2'd2, 3'b011, 32'h000080FF);
      a_single("sll_a1", 32'h80FF0011, 2'd1, 3'b010, 32'hFF001100);
      a_single("ror_a0", 32'h80FF0011, 2'd0, 3'b001, 32'h80FF0011);
      a_single("reserved", 32'hDEADBEEF, 2'd2, 3'b110, 32'hDEADBEEF);
      check("reserved_illegal", 64'(a_last_ill), 64'(1));
      a_single("sll_a3", 32'h000000FF, 2'd3, 3'b010, 32'hFF000000);
      check("sll_a3_illegal", 64'(a_last_ill), 64'(0));
      a_single("srl_to_zero", 32'h000000FF, 2'd1, 3'b011, 32'h00000000);
      check("srl_to_zero_flag", 64'(a_last_zero), 64'(1));
      b_single("b_ror_1", 32'h00000001, 5'd1, 3'b001, 32'h80000000);
      b_single("b_sra_31", 32'h80000000, 5'd31, 3'b100, 32'hFFFFFFFF);

      // Back-to-back: 8 items, tags 0..7, no backpressure
      a_out_ready = 1'b1;
      c0 = cyc;
      for (int t = 0; t < 8; t++) a_send($urandom, 2'($urandom), 3'($urandom_range(0, 4)), 4'(t));
      a_in_valid = 1'b0;
      check("b2b_accept_cycles", 64'(cyc - c0), 64'(8));
      drain_all();
      check("b2b_output_streak", 64'(a_streak), 64'(8));

      // Stall: out_ready low for 5 cycles while a stream is offered
      for (int t = 0; t < 6; t++) begin
         st_x[t] = $urandom; st_a[t] = 2'($urandom); st_op[t] = 3'($urandom_range(0, 4));
      end
      a_out_ready = 1'b0;
      o0 = a_outs;
      k = 0;
      held_set = 1'b0;
      held = '0;
      a_in_valid = 1'b1; a_operand = st_x[0]; a_amount = st_a[0]; a_op = st_op[0]; a_tag_in = 4'd0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         fired = a_in_ready;
         if (a_out_valid) begin
            if (held_set) check("stall_result_stable", 64'(a_result), 64'(held));
            else begin
               held = a_result;
               held_set = 1'b1;
            end
         end
         @(posedge clk); #1;
         if (fired) begin
            k++;
            a_operand = st_x[k]; a_amount = st_a[k]; a_op = st_op[k]; a_tag_in = 4'(k);
         end
      end
      check("stall_accepted", 64'(k), 64'(2));
      check("stall_in_ready", 64'(a_in_ready), 64'(0));
      check("stall_out_valid", 64'(a_out_valid), 64'(1));
      a_out_ready = 1'b1;
      for (int t = k; t < 6; t++) a_send(st_x[t], st_a[t], st_op[t], 4'(t));
      a_in_valid = 1'b0;
      drain_all();
      check("stall_output_count", 64'(a_outs - o0), 64'(6));

      // Reset with items in flight
      a_out_ready = 1'b0;
      b_out_ready = 1'b0;
      a_send(32'h12345678, 2'd1, 3'b000, 4'd1);
      a_send(32'h9ABCDEF0, 2'd2, 3'b001, 4'd2);
      a_in_valid = 1'b0;
      b_send(32'h0F0F0F0F, 5'd3, 3'b000, 4'd3);
      b_in_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_a_full", 64'(a_out_valid), 64'(1));
      rst_i = 1'b1;
      a_q.delete();
      b_q.delete();
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      check("mid_rst_a_out_valid", 64'(a_out_valid), 64'(0));
      check("mid_rst_a_in_ready", 64'(a_in_ready), 64'(1));
      check("mid_rst_b_out_valid", 64'(b_out_valid), 64'(0));
      check("mid_rst_b_in_ready", 64'(b_in_ready), 64'(1));
      @(posedge clk); #1;
      o0 = a_outs;
      c0 = b_outs;
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_no_stale_a", 64'(a_outs - o0), 64'(0));
      check("post_rst_no_stale_b", 64'(b_outs - c0), 64'(0));

      // Randomized traffic with random backpressure on both instances
      rand_busy = 1'b1;
      fork
         begin
            fork
               a_rand(300);
               b_rand(300);
            join
            rand_busy = 1'b0;
         end
         begin
            while (rand_busy) begin
               a_out_ready = ($urandom_range(0, 9) < 7);
               b_out_ready = ($urandom_range(0, 9) < 7);
               @(posedge clk); #1;
            end
         end
      join
      drain_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
